wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the register file's single write port between `NUM_SRC` writeback requesters (ALU, load unit, ...) in the decode/writeback path. Each cycle it grants at most one request over a valid/ready handshake and registers the winner into a one-entry output stage that drives the regfile write port. Fixed priority with starvation promotion is the default; round-robin is selectable at compile time. Writes to x0 are consumed without a regfile write.

## Interface
- `NUM_SRC`, default 2: number of writeback requesters (2..8); index 0 is highest fixed priority.
- `STARVE_LIMIT`, default 4: consecutive stalled cycles after which a requester is promoted (1..15).
- `clk_i`  in  1  clock.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  NUM_SRC  per-source write request.
- `req_addr_i`  in  NUM_SRC x reg_addr_t  per-source destination register.
- `req_data_i`  in  NUM_SRC x bus32_t  per-source write data.
- `req_ready_o`  out  NUM_SRC  one-hot-or-zero grant; the request is consumed on `valid & ready`.
- `flush_i`  in  1  synchronous pipeline flush.
- `write_enable_o`  out  1  regfile write enable.
- `addr_rd_o`  out  reg_addr_t  regfile write address.
- `data_rd_o`  out  bus32_t  regfile write data.
- `grant_idx_o`  out  $clog2(NUM_SRC)  index of the source held in the output stage (debug).

## Operation
- Arbitration is combinational. `req_ready_o` has at most one bit set, and only for a source with `req_valid_i=1`. With no valid source, `req_ready_o=0`.
- Requesters hold `req_valid_i`, `req_addr_i` and `req_data_i` stable until granted. `req_valid_i` must not depend on `req_ready_o`.
- Default policy: the lowest index wins, unless a source is starved.
  - Per-source starve counter, 4 bits, saturating at `STARVE_LIMIT`. It increments each cycle `valid & ~ready`, and clears on grant or when valid drops.
  - A source whose counter equals `STARVE_LIMIT` is starved. Starved sources take precedence over all non-starved sources; among starved sources the lowest index wins.
- On a grant, the output stage captures `{addr, data, idx}` from the winner. Next cycle, `write_enable_o = (captured addr != 0)`.
  - An x0 request is still granted and consumed, but it produces `write_enable_o=0`.
- With no grant, `write_enable_o=0` next cycle. `addr_rd_o`, `data_rd_o` and `grant_idx_o` hold their last values.
- Two sources targeting the same register are serialised. Regfile write order equals grant order.
- `flush_i=1`:
  - forces `req_ready_o=0` that cycle;
  - clears all starve counters (and the round-robin pointer, when enabled);
  - sets `write_enable_o=0` next cycle.
  - An already-registered write that is presented on the port during the flush cycle still completes.

## Timing
- Reset values: `write_enable_o=0`, `addr_rd_o=0`, `data_rd_o=0`, `grant_idx_o=0`, `req_ready_o=0` (no valids while in reset), starve counters 0, round-robin pointer 0.
- Latency: grant in cycle N; `write_enable_o`, `addr_rd_o` and `data_rd_o` are valid in cycle N+1, and the regfile updates at the end of N+1.
- Throughput: one write per cycle. The output stage never back-pressures.
- Reset asserted mid-operation clears the output stage immediately (asynchronous). No write occurs while `rstn_i=0`.
- A starved source is granted within one cycle of reaching `STARVE_LIMIT` unless a lower-index source is also starved. Worst-case wait: `NUM_SRC*(STARVE_LIMIT+1)` cycles.

## Configuration
- `WB_ARB_RR_EN` defined: round-robin policy.
  - A pointer is initialised to 0 at reset. The search starts at the pointer; on a grant to index k, the pointer moves to (k+1) mod `NUM_SRC`.
  - Starve counters and `STARVE_LIMIT` logic are compiled out; the parameter is ignored.
- `WB_ARB_RR_EN` undefined: fixed priority with starvation promotion, as in Operation.

## Test plan
- Reset, then src0 valid with addr 5, data 0xDEADBEEF -> `req_ready_o=01` the same cycle; next cycle `write_enable_o=1`, `addr_rd_o=5`, `data_rd_o=0xDEADBEEF`, `grant_idx_o=0`.
- src0 and src1 valid continuously (default build, `STARVE_LIMIT=4`) -> src1 stalls 4 cycles, is granted in the 5th cycle, its counter clears, then src0 resumes.
- src1 valid with addr 0, data 0x1234 -> granted; next cycle `write_enable_o=0`.
- src0 and src1 both target addr 7 with 0xA and 0xB -> two consecutive writes in grant order; reading back through the regfile returns the second-granted value.
- `flush_i` pulse while both sources are valid -> `req_ready_o=0` that cycle; `write_enable_o=0` next cycle; starve counters read 0; arbitration resumes the cycle after.
- `WB_ARB_RR_EN` build with 3 sources all valid -> grants 0,1,2,0,1,2 on successive cycles; assert `rstn_i` low mid-sequence -> `write_enable_o` drops immediately and the pointer restarts at 0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single regfile write port among NUM_SRC
// writeback requesters. The winner is chosen combinationally each cycle and
// registered into a one-entry output stage that drives the write port.
// Writes to x0 are consumed but never produce a write enable.
//
// Policy: fixed priority (index 0 highest), with starvation promotion after
// STARVE_LIMIT consecutive stalled cycles. Define WB_ARB_RR_EN to select a
// round-robin policy instead; the starve counters are then compiled out.
//
// Ports:
//   clk_i, rstn_i   clock, asynchronous active-low reset
//   req_valid_i     per-source write request
//   req_addr_i      per-source destination register, 5 bits per source
//   req_data_i      per-source write data, 32 bits per source
//   req_ready_o     one-hot-or-zero grant (combinational)
//   flush_i         synchronous flush: no grant, clears arbitration state
//   write_enable_o  regfile write enable (registered)
//   addr_rd_o       regfile write address (registered)
//   data_rd_o       regfile write data (registered)
//   grant_idx_o     source index held in the output stage (debug)
module wb_port_arbiter #(
    parameter int unsigned NUM_SRC      = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic [NUM_SRC-1:0]         req_valid_i,
    input  logic [NUM_SRC*5-1:0]       req_addr_i,
    input  logic [NUM_SRC*32-1:0]      req_data_i,
    output logic [NUM_SRC-1:0]         req_ready_o,
    input  logic                       flush_i,
    output logic                       write_enable_o,
    output logic [4:0]                 addr_rd_o,
    output logic [31:0]                data_rd_o,
    output logic [$clog2(NUM_SRC)-1:0] grant_idx_o
);

    localparam int unsigned IDX_W  = $clog2(NUM_SRC);
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    logic [ADDR_W-1:0] addr_arr [NUM_SRC];
    logic [DATA_W-1:0] data_arr [NUM_SRC];

    logic              grant_any;
    logic [IDX_W-1:0]  grant_idx;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    // Unpack the flattened request buses
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            addr_arr[i] = req_addr_i[i*ADDR_W +: ADDR_W];
            data_arr[i] = req_data_i[i*DATA_W +: DATA_W];
        end
    end

`ifdef WB_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] cand;

    // Round-robin search from the pointer; walking backwards lets the
    // nearest valid source overwrite farther ones.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned off = NUM_SRC; off > 0; off--) begin
            cand = IDX_W'((32'(ptr_q) + off - 1) % NUM_SRC);
            if (req_valid_i[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (flush_i) begin
            grant_any = 1'b0;
        end
    end

    // Pointer moves just past the winner; flush restarts it at 0
    always_comb begin
        ptr_d = ptr_q;
        if (flush_i) begin
            ptr_d = '0;
        end else if (grant_any) begin
            ptr_d = (grant_idx == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] cnt_q [NUM_SRC];
    logic [3:0] cnt_d [NUM_SRC];

    // Lowest valid index wins, then a starved source (lowest index among
    // starved) overrides it.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_valid_i[i] && (cnt_q[i] == LIMIT)) begin
                grant_idx = IDX_W'(i);
            end
        end
        if (flush_i) begin
            grant_any = 1'b0;
        end
    end

    // Starve counters: saturating count of consecutive stalled cycles
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            cnt_d[i] = '0;
            if (!flush_i && req_valid_i[i] && !req_ready_o[i]) begin
                cnt_d[i] = (cnt_q[i] == LIMIT) ? cnt_q[i] : cnt_q[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`endif

    // One-hot grant
    always_comb begin
        req_ready_o = '0;
        if (grant_any) begin
            req_ready_o = NUM_SRC'(1) << grant_idx;
        end
    end

    // Output stage: capture the winner; hold payload when idle
    always_comb begin
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        idx_d  = idx_q;
        if (grant_any) begin
            we_d   = (addr_arr[grant_idx] != '0);
            addr_d = addr_arr[grant_idx];
            data_d = data_arr[grant_idx];
            idx_d  = grant_idx;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            idx_q  <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            idx_q  <= idx_d;
        end
    end

    assign write_enable_o = we_q;
    assign addr_rd_o      = addr_q;
    assign data_rd_o      = data_q;
    assign grant_idx_o    = idx_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter with three sources and STARVE_LIMIT=4.
// Inputs change on the falling edge; the combinational grant is sampled 1ns
// later and registered outputs are sampled on the next falling edge.
module tb_wb_port_arbiter;

    localparam int unsigned N = 3;

    logic           clk;
    logic           rstn;
    logic [N-1:0]   valid;
    logic [N*5-1:0] addr;
    logic [N*32-1:0] data;
    logic [N-1:0]   ready;
    logic           flush;
    logic           we;
    logic [4:0]     addr_rd;
    logic [31:0]    data_rd;
    logic [1:0]     gidx;

    logic [31:0]    rf [32];

    int total;
    int bad;

    wb_port_arbiter #(.NUM_SRC(N), .STARVE_LIMIT(4)) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .req_valid_i    (valid),
        .req_addr_i     (addr),
        .req_data_i     (data),
        .req_ready_o    (ready),
        .flush_i        (flush),
        .write_enable_o (we),
        .addr_rd_o      (addr_rd),
        .data_rd_o      (data_rd),
        .grant_idx_o    (gidx)
    );

    always #5 clk = ~clk;

    // Regfile model fed by the write port
    always @(posedge clk) begin
        if (rstn && we) rf[addr_rd] <= data_rd;
    end

    task automatic set_src(input int s, input logic v, input logic [4:0] a, input logic [31:0] d);
        valid[s]        = v;
        addr[s*5 +: 5]  = a;
        data[s*32 +: 32] = d;
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rstn  = 1'b0;
        valid = '0;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        #12;
        total++; if (we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", we); end
        total++; if (addr_rd !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", addr_rd); end
        total++; if (data_rd !== 32'd0) begin bad++; $display("FAIL reset_data got=%h want=0", data_rd); end
        total++; if (gidx !== 2'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", gidx); end
        total++; if (ready !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b want=000", ready); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_basic;
        apply_reset();
        @(negedge clk);
        set_src(0, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        total++; if (ready !== 3'b001) begin bad++; $display("FAIL basic_ready got=%b want=001", ready); end
        @(negedge clk);
        valid = '0;
        total++; if (we !== 1'b1) begin bad++; $display("FAIL basic_we got=%b want=1", we); end
        total++; if (addr_rd !== 5'd5) begin bad++; $display("FAIL basic_addr got=%0d want=5", addr_rd); end
        total++; if (data_rd !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_data got=%h want=deadbeef", data_rd); end
        total++; if (gidx !== 2'd0) begin bad++; $display("FAIL basic_idx got=%0d want=0", gidx); end
        #1;
        total++; if (ready !== 3'b000) begin bad++; $display("FAIL idle_ready got=%b want=000", ready); end
        @(negedge clk);
        total++; if (we !== 1'b0) begin bad++; $display("FAIL idle_we got=%b want=0", we); end
        total++; if (addr_rd !== 5'd5) begin bad++; $display("FAIL idle_addr_hold got=%0d want=5", addr_rd); end
    endtask

    task automatic test_x0;
        apply_reset();
        @(negedge clk);
        set_src(1, 1'b1, 5'd0, 32'h1234);
        #1;
        total++; if (ready !== 3'b010) begin bad++; $display("FAIL x0_ready got=%b want=010", ready); end
        @(negedge clk);
        valid = '0;
        total++; if (we !== 1'b0) begin bad++; $display("FAIL x0_we got=%b want=0", we); end
        total++; if (gidx !== 2'd1) begin bad++; $display("FAIL x0_idx got=%0d want=1", gidx); end
        total++; if (data_rd !== 32'h1234) begin bad++; $display("FAIL x0_data got=%h want=1234", data_rd); end
    endtask

    task automatic test_back_to_back;
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c > 0) begin
                total++; if (we !== 1'b1) begin bad++; $display("FAIL b2b_we c=%0d got=%b want=1", c, we); end
                total++; if (addr_rd !== 5'(c)) begin bad++; $display("FAIL b2b_addr c=%0d got=%0d want=%0d", c, addr_rd, c); end
                total++; if (data_rd !== 32'h1000 + 32'(c - 1)) begin bad++; $display("FAIL b2b_data c=%0d got=%h want=%h", c, data_rd, 32'h1000 + 32'(c - 1)); end
            end
            set_src(0, 1'b1, 5'(c + 1), 32'h1000 + 32'(c));
            #1;
            total++; if (ready !== 3'b001) begin bad++; $display("FAIL b2b_ready c=%0d got=%b want=001", c, ready); end
        end
        @(negedge clk);
        total++; if (data_rd !== 32'h1003) begin bad++; $display("FAIL b2b_last got=%h want=1003", data_rd); end
        #2;
        rstn  = 1'b0;
        valid = '0;
        #1;
        total++; if (we !== 1'b0) begin bad++; $display("FAIL async_rst_we got=%b want=0", we); end
        total++; if (addr_rd !== 5'd0) begin bad++; $display("FAIL async_rst_addr got=%0d want=0", addr_rd); end
        total++; if (data_rd !== 32'd0) begin bad++; $display("FAIL async_rst_data got=%h want=0", data_rd); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_same_addr;
        apply_reset();
        @(negedge clk);
        set_src(0, 1'b1, 5'd7, 32'hA);
        set_src(1, 1'b1, 5'd7, 32'hB);
        #1;
        total++; if (ready !== 3'b001) begin bad++; $display("FAIL same_ready0 got=%b want=001", ready); end
        @(negedge clk);
        valid[0] = 1'b0;
        total++; if (data_rd !== 32'hA || we !== 1'b1) begin bad++; $display("FAIL same_first got=%h/%b want=a/1", data_rd, we); end
        #1;
        total++; if (ready !== 3'b010) begin bad++; $display("FAIL same_ready1 got=%b want=010", ready); end
        @(negedge clk);
        valid = '0;
        total++; if (data_rd !== 32'hB || we !== 1'b1) begin bad++; $display("FAIL same_second got=%h/%b want=b/1", data_rd, we); end
        @(negedge clk);
        total++; if (rf[7] !== 32'hB) begin bad++; $display("FAIL same_rf7 got=%h want=b", rf[7]); end
    endtask

    task automatic test_flush;
        logic [2:0] exp;
        apply_reset();
        set_src(0, 1'b1, 5'd3, 32'h300);
        set_src(1, 1'b1, 5'd4, 32'h400);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
`ifdef WB_ARB_RR_EN
            exp = (c == 0) ? 3'b001 : 3'b010;
`else
            exp = 3'b001;
`endif
            total++; if (ready !== exp) begin bad++; $display("FAIL pre_flush_ready c=%0d got=%b want=%b", c, ready, exp); end
        end
        @(negedge clk);
        flush = 1'b1;
        total++; if (we !== 1'b1) begin bad++; $display("FAIL flush_inflight_we got=%b want=1", we); end
        #1;
        total++; if (ready !== 3'b000) begin bad++; $display("FAIL flush_ready got=%b want=000", ready); end
        @(negedge clk);
        flush = 1'b0;
        total++; if (we !== 1'b0) begin bad++; $display("FAIL flush_we got=%b want=0", we); end
        // Cleared counters/pointer: src1 waits a full starve window again
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            #1;
`ifdef WB_ARB_RR_EN
            exp = (c % 2 == 0) ? 3'b001 : 3'b010;
`else
            exp = (c == 4) ? 3'b010 : 3'b001;
`endif
            total++; if (ready !== exp) begin bad++; $display("FAIL post_flush_ready c=%0d got=%b want=%b", c, ready, exp); end
        end
        @(negedge clk);
        valid = '0;
    endtask

    task automatic test_starvation;
        logic [2:0] exp;
        logic [1:0] prev;
        apply_reset();
        prev = 2'd0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin
                set_src(0, 1'b1, 5'd1, 32'h100);
                set_src(1, 1'b1, 5'd2, 32'h200);
            end else begin
                total++; if (gidx !== prev || we !== 1'b1) begin bad++; $display("FAIL starve_out c=%0d got=%0d/%b want=%0d/1", c, gidx, we, prev); end
            end
            exp = (c == 4 || c == 9) ? 3'b010 : 3'b001;
            prev = (exp == 3'b010) ? 2'd1 : 2'd0;
            #1;
            total++; if (ready !== exp) begin bad++; $display("FAIL starve_ready c=%0d got=%b want=%b", c, ready, exp); end
        end
        @(negedge clk);
        valid = '0;
        total++; if (addr_rd !== 5'd2) begin bad++; $display("FAIL starve_addr got=%0d want=2", addr_rd); end
    endtask

    task automatic test_rr;
        logic [2:0] exp;
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) begin
                set_src(0, 1'b1, 5'd1, 32'h10);
                set_src(1, 1'b1, 5'd2, 32'h20);
                set_src(2, 1'b1, 5'd3, 32'h30);
            end else begin
                total++; if (gidx !== 2'((c - 1) % 3)) begin bad++; $display("FAIL rr_idx c=%0d got=%0d want=%0d", c, gidx, (c - 1) % 3); end
            end
            exp = 3'b001 << (c % 3);
            #1;
            total++; if (ready !== exp) begin bad++; $display("FAIL rr_ready c=%0d got=%b want=%b", c, ready, exp); end
        end
        @(negedge clk);
        total++; if (we !== 1'b1 || gidx !== 2'd1) begin bad++; $display("FAIL rr_pre_rst got=%b/%0d want=1/1", we, gidx); end
        #2;
        rstn  = 1'b0;
        valid = '0;
        #1;
        total++; if (we !== 1'b0) begin bad++; $display("FAIL rr_rst_we got=%b want=0", we); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        valid = 3'b111;
        #1;
        total++; if (ready !== 3'b001) begin bad++; $display("FAIL rr_ptr_restart got=%b want=001", ready); end
        @(negedge clk);
        valid = '0;
    endtask

    initial begin
        clk   = 1'b0;
        rstn  = 1'b0;
        valid = '0;
        addr  = '0;
        data  = '0;
        flush = 1'b0;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        test_reset();
        test_basic();
        test_x0();
        test_back_to_back();
        test_same_addr();
        test_flush();
`ifdef WB_ARB_RR_EN
        test_rr();
`else
        test_starvation();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
